mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 Port list SHALL be, in this order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- A  in  32  operand A (multiplicand / dividend), two's complement
- B  in  32  operand B (multiplier / divisor), two's complement
- mult_start  in  1  request signed multiply
- div_start  in  1  request signed divide
- Hiout  out  32  HI register (product high word / remainder)
- Loout  out  32  LO register (product low word / quotient)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle divide-by-zero pulse
REQ-003 Hiout and Loout SHALL be driven directly from internal registers, with no combinational path from A, B or the start inputs.

Function
REQ-004 The FSM SHALL have three states, IDLE, MULT and DIV, and SHALL reset to IDLE.
REQ-005 In IDLE, a rising edge with mult_start=1 SHALL latch A and B, clear the step counter to 0 and enter MULT.
REQ-006 In IDLE, a rising edge with div_start=1, mult_start=0 and B!=0 SHALL latch A and B, clear the counter and enter DIV.
REQ-007 If mult_start and div_start are both high in IDLE, multiply SHALL win and the divide request SHALL be dropped.
REQ-008 Start inputs SHALL be ignored outside IDLE; no queuing.
REQ-009 MULT SHALL perform radix-2 Booth steps on a 65-bit accumulator {HI,LO,q-1}, one step per clock, 32 steps, arithmetic right shift.
REQ-010 DIV SHALL perform a restoring divide on operand magnitudes, one quotient bit per clock, 32 steps.
REQ-011 Signed results SHALL be fixed up on the final step edge.
- Quotient SHALL truncate toward zero.
- Remainder SHALL take the sign of the dividend.
REQ-012 Latency: for a start accepted at edge k, Hiout/Loout SHALL update at edge k+32, and the FSM SHALL return to IDLE at the same edge.
REQ-013 busy SHALL be 1 in MULT and DIV and 0 in IDLE; the earliest next accepted start is edge k+33.
REQ-014 done SHALL be registered and high only for the cycle between edges k+32 and k+33.
REQ-015 MULT result: Hiout = product[63:32], Loout = product[31:0] of the full signed 64-bit product.
REQ-016 DIV result: Loout = quotient, Hiout = remainder.
REQ-017 For 0x80000000 / 0xFFFFFFFF the result SHALL be Loout=0x80000000, Hiout=0 with no exception.
REQ-018 A divide start with B=0 SHALL stay in IDLE and leave Hiout/Loout unchanged; done and div_zero SHALL both pulse high for exactly the following cycle.
REQ-019 Hiout/Loout SHALL hold their values between operations and SHALL never show intermediate accumulator values.

Reset
REQ-020 Reset low SHALL asynchronously force: state=IDLE, counter=0, Hiout=0, Loout=0, busy=0, done=0, div_zero=0, operand latches=0.
REQ-021 Reset during MULT or DIV SHALL abort the operation with no result written; the first start after reset release SHALL behave as from power-up.

Structure
REQ-022 A shared package mult_div_pkg SHALL hold:
- the state encoding (IDLE=2'b00, MULT=2'b01, DIV=2'b10)
- ITERATIONS=32
- the 32-bit word width constant
REQ-023 The unit SHALL be a single module with no sub-modules; the 6-bit step counter, accumulators and FSM SHALL live in one sequential process, with next-step arithmetic in combinational logic.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- A=7, B=0xFFFFFFFD, mult_start one cycle -> Hiout=0xFFFFFFFF, Loout=0xFFFFFFEB at edge k+32; done high exactly one cycle; busy high for 32 cycles.
- A=0xFFFFFFF9 (-7), B=2, div_start -> Loout=0xFFFFFFFD, Hiout=0xFFFFFFFF.
- A=5, B=0, div_start with Hiout=0x11, Loout=0x22 preloaded -> div_zero=done=1 next cycle; Hiout/Loout unchanged; busy stays 0.
- A=0x80000000, B=0xFFFFFFFF, div_start -> Loout=0x80000000, Hiout=0, div_zero=0.
- mult_start and div_start both high with A=3, B=4 -> Loout=12, Hiout=0; a second mult_start at edge k+10 is ignored, with the result still at k+32.
- reset low at edge k+15 of a multiply -> all outputs 0 immediately; no done pulse; a new multiply after release completes in 32 cycles.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared constants and state encoding for the signed multiply/divide unit.
package mult_div_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int ITERATIONS = 32;
  localparam int ACC_WIDTH  = 2 * WORD_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10
  } state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide, one step per clock.
// Results land in HI/LO registers that only change on the final step edge.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] A,
  input  logic [WORD_WIDTH-1:0] B,
  input  logic                  mult_start,
  input  logic                  div_start,
  output logic [WORD_WIDTH-1:0] Hiout,
  output logic [WORD_WIDTH-1:0] Loout,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero
);

  localparam logic [5:0] LAST_STEP = 6'(ITERATIONS - 1);

  state_t                 state_reg, state_next;
  logic [5:0]             count_reg;
  logic [WORD_WIDTH-1:0]  a_reg, b_reg;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic [WORD_WIDTH-1:0]  hi_reg, lo_reg;
  logic                   done_reg, div_zero_reg;

  logic                   last_step;
  logic [WORD_WIDTH-1:0]  a_mag_in, b_mag;
  logic [WORD_WIDTH:0]    booth_sum;
  logic [ACC_WIDTH-1:0]   booth_next;
  logic [WORD_WIDTH:0]    div_shifted, div_trial;
  logic                   div_fits;
  logic [ACC_WIDTH-1:0]   div_next;
  logic [WORD_WIDTH-1:0]  quo_fixed, rem_fixed;

  // Booth step: HI is sign-extended to 33 bits so adding/subtracting -2^31 cannot overflow.
  always_comb begin
    booth_sum = {acc_reg[ACC_WIDTH-1], acc_reg[ACC_WIDTH-1:WORD_WIDTH+1]};
    case (acc_reg[1:0])
      2'b01:   booth_sum = booth_sum + {a_reg[WORD_WIDTH-1], a_reg};
      2'b10:   booth_sum = booth_sum - {a_reg[WORD_WIDTH-1], a_reg};
      default: booth_sum = booth_sum;
    endcase
    booth_next = {booth_sum, acc_reg[WORD_WIDTH:1]};
  end

  // Restoring divide on magnitudes: acc holds {remainder, quotient-in-progress, unused}.
  always_comb begin
    a_mag_in    = A[WORD_WIDTH-1] ? (~A + 1'b1) : A;
    b_mag       = b_reg[WORD_WIDTH-1] ? (~b_reg + 1'b1) : b_reg;
    div_shifted = {acc_reg[ACC_WIDTH-1:WORD_WIDTH+1], acc_reg[WORD_WIDTH]};
    div_trial   = div_shifted - {1'b0, b_mag};
    div_fits    = ~div_trial[WORD_WIDTH];
    div_next    = {(div_fits ? div_trial[WORD_WIDTH-1:0] : div_shifted[WORD_WIDTH-1:0]),
                   acc_reg[WORD_WIDTH-1:1], div_fits, 1'b0};
    quo_fixed   = (a_reg[WORD_WIDTH-1] ^ b_reg[WORD_WIDTH-1])
                  ? (~div_next[WORD_WIDTH:1] + 1'b1) : div_next[WORD_WIDTH:1];
    rem_fixed   = a_reg[WORD_WIDTH-1]
                  ? (~div_next[ACC_WIDTH-1:WORD_WIDTH+1] + 1'b1) : div_next[ACC_WIDTH-1:WORD_WIDTH+1];
  end

  always_comb begin
    last_step  = (count_reg == LAST_STEP);
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mult_start)
          state_next = MULT;
        else if (div_start && (B != '0))
          state_next = DIV;
      end
      MULT, DIV: if (last_step) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mult_start) begin
            a_reg     <= A;
            b_reg     <= B;
            count_reg <= '0;
            acc_reg   <= {{WORD_WIDTH{1'b0}}, B, 1'b0};
          end else if (div_start) begin
            if (B == '0) begin
              done_reg     <= 1'b1;
              div_zero_reg <= 1'b1;
            end else begin
              a_reg     <= A;
              b_reg     <= B;
              count_reg <= '0;
              acc_reg   <= {{WORD_WIDTH{1'b0}}, a_mag_in, 1'b0};
            end
          end
        end
        MULT: begin
          acc_reg   <= booth_next;
          count_reg <= count_reg + 6'd1;
          if (last_step) begin
            hi_reg   <= booth_next[ACC_WIDTH-1:WORD_WIDTH+1];
            lo_reg   <= booth_next[WORD_WIDTH:1];
            done_reg <= 1'b1;
          end
        end
        DIV: begin
          acc_reg   <= div_next;
          count_reg <= count_reg + 6'd1;
          if (last_step) begin
            hi_reg   <= rem_fixed;
            lo_reg   <= quo_fixed;
            done_reg <= 1'b1;
          end
        end
        default: count_reg <= '0;
      endcase
    end
  end

  always_comb begin
    busy     = (state_reg != IDLE);
    Hiout    = hi_reg;
    Loout    = lo_reg;
    done     = done_reg;
    div_zero = div_zero_reg;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed results, divide-by-zero, reset abort.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        mult_start = 1'b0, div_start = 1'b0;
  logic [31:0] Hiout, Loout;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .A(A), .B(B),
    .mult_start(mult_start), .div_start(div_start),
    .Hiout(Hiout), .Loout(Loout), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Drives one start pulse (accepted at edge k) and samples 40 negedges after it;
  // sample n lies between edges k+n and k+n+1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic ms, input logic ds, input int restart_at,
                        output int busy_cycles, output int done_at, output int done_count,
                        output int dz_count, output int changed);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = Hiout; lo0 = Loout;
    A = a; B = b; mult_start = ms; div_start = ds;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    busy_cycles = 0; done_at = -1; done_count = 0; dz_count = 0; changed = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        if (done_at < 0) done_at = n;
      end
      if (div_zero) dz_count++;
      if (n < 32 && (Hiout !== hi0 || Loout !== lo0)) changed++;
      if (n == restart_at - 1) begin
        A = 32'd9; B = 32'd9; mult_start = 1'b1;
      end else begin
        mult_start = 1'b0;
      end
      @(negedge clk);
    end
    $display("op ms=%0b ds=%0b A=%h B=%h -> Hi=%h Lo=%h done_at=%0d busy_cycles=%0d dz=%0d",
             ms, ds, a, b, Hiout, Loout, done_at, busy_cycles, dz_count);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({Hiout, Loout, busy, done, div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: got Hi=%h Lo=%h busy=%b done=%b dz=%b required all zero",
               Hiout, Loout, busy, done, div_zero);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult_basic();
    int bc, da, dc, dz, ch;
    run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, -1, bc, da, dc, dz, ch);
    checks++; if (Hiout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult7_hi: got %h required ffffffff", Hiout); end
    checks++; if (Loout !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult7_lo: got %h required ffffffeb", Loout); end
    checks++; if (da !== 32 || dc !== 1) begin errors++; $display("FAIL mult7_done: first at %0d count %0d required 32 and 1", da, dc); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL mult7_busy: got %0d cycles required 32", bc); end
    checks++; if (ch !== 0) begin errors++; $display("FAIL mult7_hold: outputs changed in %0d samples before k+32 required 0", ch); end
  endtask

  task automatic test_mult_vectors();
    logic [31:0] va [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF};
    logic [31:0] vb [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0010, 32'h8000_0000};
    logic [31:0] eh [4] = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0001, 32'hC000_0000};
    logic [31:0] el [4] = '{32'h0000_0000, 32'h0000_0001, 32'h2345_6780, 32'h8000_0000};
    int bc, da, dc, dz, ch;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 1'b1, 1'b0, -1, bc, da, dc, dz, ch);
      checks++;
      if (Hiout !== eh[i] || Loout !== el[i] || da !== 32) begin
        errors++;
        $display("FAIL mult_vec%0d: got Hi=%h Lo=%h done_at=%0d required Hi=%h Lo=%h done_at=32",
                 i, Hiout, Loout, da, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div_signed();
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd100, 32'hFFFF_FF9C, 32'h7FFF_FFFF};
    logic [31:0] vb [4] = '{32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'h0000_000E, 32'h0000_0000};
    logic [31:0] er [4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    int bc, da, dc, dz, ch;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 1'b0, 1'b1, -1, bc, da, dc, dz, ch);
      checks++;
      if (Loout !== eq[i] || Hiout !== er[i] || da !== 32 || bc !== 32) begin
        errors++;
        $display("FAIL div_vec%0d: got Lo=%h Hi=%h done_at=%0d busy=%0d required Lo=%h Hi=%h done_at=32 busy=32",
                 i, Loout, Hiout, da, bc, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int bc, da, dc, dz, ch;
    run_op(32'h451, 32'h20, 1'b0, 1'b1, -1, bc, da, dc, dz, ch);
    checks++;
    if (Hiout !== 32'h11 || Loout !== 32'h22) begin
      errors++; $display("FAIL divz_preload: got Hi=%h Lo=%h required 11 and 22", Hiout, Loout);
    end
    run_op(32'd5, 32'd0, 1'b0, 1'b1, -1, bc, da, dc, dz, ch);
    checks++; if (da !== 0 || dc !== 1) begin errors++; $display("FAIL divz_done: first at %0d count %0d required 0 and 1", da, dc); end
    checks++; if (dz !== 1) begin errors++; $display("FAIL divz_flag: div_zero high %0d cycles required 1", dz); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL divz_busy: busy %0d cycles required 0", bc); end
    checks++;
    if (Hiout !== 32'h11 || Loout !== 32'h22 || ch !== 0) begin
      errors++; $display("FAIL divz_hold: got Hi=%h Lo=%h changes=%0d required 11 22 0", Hiout, Loout, ch);
    end
  endtask

  task automatic test_div_overflow();
    int bc, da, dc, dz, ch;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, -1, bc, da, dc, dz, ch);
    checks++;
    if (Loout !== 32'h8000_0000 || Hiout !== 32'h0 || dz !== 0 || da !== 32) begin
      errors++;
      $display("FAIL div_ovf: got Lo=%h Hi=%h dz=%0d done_at=%0d required 80000000 0 0 32", Loout, Hiout, dz, da);
    end
  endtask

  task automatic test_both_start();
    int bc, da, dc, dz, ch;
    run_op(32'd3, 32'd4, 1'b1, 1'b1, 10, bc, da, dc, dz, ch);
    checks++; if (Loout !== 32'd12 || Hiout !== 32'd0) begin errors++; $display("FAIL both_result: got Hi=%h Lo=%h required 0 and c", Hiout, Loout); end
    checks++; if (da !== 32 || dc !== 1 || bc !== 32) begin errors++; $display("FAIL both_timing: done_at=%0d count=%0d busy=%0d required 32 1 32", da, dc, bc); end
  endtask

  task automatic test_reset_abort();
    int bc, da, dc, dz, ch, seen_done;
    @(negedge clk);
    A = 32'd6; B = 32'd7; mult_start = 1'b1;
    @(posedge clk);
    #1 mult_start = 1'b0;
    repeat (15) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({Hiout, Loout, busy, done, div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL abort_outputs: got Hi=%h Lo=%h busy=%b done=%b dz=%b required all zero",
               Hiout, Loout, busy, done, div_zero);
    end
    seen_done = 0;
    repeat (3) begin @(negedge clk); if (done) seen_done++; end
    reset = 1'b1;
    repeat (20) begin @(negedge clk); if (done || busy) seen_done++; end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_quiet: done/busy seen %0d times required 0", seen_done); end
    run_op(32'hFFFF_FFFE, 32'd5, 1'b1, 1'b0, -1, bc, da, dc, dz, ch);
    checks++;
    if (Hiout !== 32'hFFFF_FFFF || Loout !== 32'hFFFF_FFF6 || da !== 32 || bc !== 32) begin
      errors++;
      $display("FAIL abort_rerun: got Hi=%h Lo=%h done_at=%0d busy=%0d required ffffffff fffffff6 32 32",
               Hiout, Loout, da, bc);
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_vectors();
    test_div_signed();
    test_div_zero();
    test_div_overflow();
    test_both_start();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
